serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial N-bit adder that consumes the sum/carry outputs of a one-bit full-adder cell, one operand bit per clock, LSB first.
- Carry is held in a flip-flop between bits. Sum bits are shifted into a result register.
- Sits between the operand source (register file / test harness) and any consumer that needs a registered N-bit sum plus carry-out with a done strobe.
- Trades latency for area: one full-adder cell regardless of WIDTH.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 1 or more.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle strobe; sum and cout are valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at a rising edge) forces:
  - state to IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - operand shift registers, carry FF and bit counter to 0.
- Reset mid-operation aborts the add. No done is produced, and the partial sum is discarded (sum reads 0).
- State IDLE:
  - start=1 at an edge loads a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, and moves to SHIFT.
  - start=0 stays in IDLE.
- State SHIFT (one edge per bit):
  - The full-adder cell takes a_sr[0], b_sr[0] and carry.
  - Update: sum_sr <= {s, sum_sr[WIDTH-1:1]}; carry <= c; a_sr and b_sr shift right, zero-filled; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1, also load sum<=final sum_sr and cout<=final carry, then move to DONE.
- State DONE: done=1 for exactly one cycle, then unconditionally back to IDLE.
- Latency:
  - start sampled at edge 0; shifts occur on edges 1..WIDTH.
  - done is high during the cycle after edge WIDTH.
  - Next start can be accepted at edge WIDTH+2.
- start is ignored in SHIFT and DONE. There is no queueing, and operands captured earlier are unaffected.
- sum and cout hold their values from DONE until the next accepted start loads new operands. sum and cout are not cleared on accept.
- WIDTH=1: a single SHIFT edge, then DONE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- busy and done are never high together.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port `sub` (1 bit), sampled with start.
  - sub=1 loads b_sr<=~b and carry<=1; cin is ignored.
  - Result is a-b; cout=1 means no borrow.
  - sub=0 behaves exactly as the base block.
- Undefined: no `sub` port; add only.

Decomposition:
- Package serial_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2, plus a 2-bit state typedef;
  - the CNT_W derivation function.
- One sub-module, fa_bit: a combinational one-bit full adder (inputs x, y, ci; outputs s, co), instantiated once.
- Everything else (FSM, shift registers, counter, carry FF) stays in serial_adder.

Test Plan (WIDTH=8):
- Basic add: a=8'h35, b=8'h4A, cin=0, start pulse → busy for 8 cycles, done in cycle 9 after start, sum=8'h7F, cout=0.
- Carry ripple: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Busy lockout: start with a=8'h01, b=8'h02; re-assert start at shift 3 with a=8'hF0, b=8'h0F → single done, sum=8'h03. A second start sampled at edge 10 yields sum=8'hFF.
- Reset mid-op: start a=8'h55, b=8'h55; drive rst_n=0 at shift 4 → next cycle busy=0, sum=0, cout=0, no done. Release, start a=8'h02, b=8'h03 → sum=8'h05.
- Back-to-back: start held high continuously → result every 10 cycles. done never overlaps busy, and sum updates only on the done cycle.
- With SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=8'h10, b=8'h01 → sum=8'h0F, cout=1.
  - sub=1, a=8'h00, b=8'h01 → sum=8'hFF, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the bit-counter width derivation.
package serial_adder_pkg;

  // IDLE waits for start, SHIFT processes one bit per clock, DONE strobes once.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // The counter must represent 0..WIDTH-1 with headroom, including WIDTH=1.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder; the only arithmetic cell in the
// serial adder, reused for every bit position over time.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are captured on an accepted start,
// then one bit per clock (LSB first) passes through a single full-adder
// cell, with the carry held in a flip-flop between bits. The registered
// sum/cout are presented with a one-cycle done strobe.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a `sub` input that
// turns the operation into a - b (cout=1 means no borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sr_reg;
  logic [WIDTH-1:0]   b_sr_reg;
  logic [WIDTH-1:0]   sum_sr_reg;
  logic [WIDTH-1:0]   sum_sr_next;
  logic               carry_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               last_bit;
  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;
  logic               unused_sum_lsb;

  // The single arithmetic cell, fed from the operand LSBs and the carry FF.
  fa_bit u_fa (
    .x  (a_sr_reg[0]),
    .y  (b_sr_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; everything else moves one place down.
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
    assign sum_sr_next[gi] = sum_sr_reg[gi+1];
  end
  assign sum_sr_next[WIDTH-1] = fa_s;

  // The shift-register LSB falls off the end on every shift and is never consumed.
  assign unused_sum_lsb = sum_sr_reg[0];

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  // Operand conditioning at capture time: subtract is a + ~b + 1.
  always_comb begin
    b_load     = b;
    carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load     = ~b;
      carry_load = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and status decode; start only matters in IDLE.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, one bit per clock in SHIFT, publish on the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      sum_sr_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      sum        <= '0;
      cout       <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b_load;
            carry_reg <= carry_load;
            cnt_reg   <= '0;
          end
        end
        ST_SHIFT: begin
          sum_sr_reg <= sum_sr_next;
          carry_reg  <= fa_co;
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_bit) begin
            sum  <= sum_sr_next;
            cout <= fa_co;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
